// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron loader and trainer: header byte, word width and
// the loader state encoding.
package perceptron_pkg;

    localparam int unsigned WORD_W = 8;
    localparam logic [WORD_W-1:0] HEADER_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStream,
        StDone
    } loader_state_e;

endpackage

// File: rtl/sample_regfile.sv
// Training-sample store: one byte per (sample, slot), slot DIM holds the label.
// Synchronous write of one byte, combinational read of a whole sample.
module sample_regfile
    import perceptron_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 3,
    parameter int unsigned DIM       = 2,
    parameter int unsigned SMP_W     = 2,
    parameter int unsigned SLOT_W    = 2,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [SMP_W-1:0]        wr_sample_i,
    input  logic [SLOT_W-1:0]       wr_slot_i,
    input  logic [WORD_W-1:0]       wr_data_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic [DIM*WORD_W-1:0]   rd_x_o,
    output logic [WORD_W-1:0]       rd_y_o
);

    logic [WORD_W-1:0] mem_q [N_SAMPLES][DIM+1];

    // Contents are deliberately left unreset; the loader never exposes them before a
    // frame has passed its checksum.
    always_ff @(posedge clk_i) begin
        for (int s = 0; s < int'(N_SAMPLES); s++) begin
            for (int k = 0; k <= int'(DIM); k++) begin
                if (we_i && wr_sample_i == SMP_W'(s) && wr_slot_i == SLOT_W'(k)) begin
                    mem_q[s][k] <= wr_data_i;
                end
            end
        end
    end

    always_comb begin
        rd_x_o = '0;
        for (int k = 0; k < int'(DIM); k++) begin
            rd_x_o[k*WORD_W +: WORD_W] = mem_q[rd_idx_i][k];
        end
        rd_y_o = mem_q[rd_idx_i][DIM];
    end

endmodule

// File: rtl/perceptron_sample_loader.sv
// Loads a checksummed byte-serial training frame into a local register file, then replays
// the samples to the trainer over a valid/ready stream for N_EPOCHS passes.
module perceptron_sample_loader
    import perceptron_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 3,
    parameter int unsigned DIM       = 2,
    parameter int unsigned N_EPOCHS  = 4,
    parameter logic [7:0]  HEADER    = HEADER_BYTE,
    localparam int unsigned IDX_W    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
    localparam int unsigned EP_W     = $clog2(N_EPOCHS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DIM*8-1:0]      out_x,
    output logic [7:0]            out_y,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EP_W-1:0]       epoch,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned SMP_W  = $clog2(N_SAMPLES + 1);
    localparam int unsigned SLOT_W = $clog2(DIM + 1);
    localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(N_SAMPLES - 1);
    localparam logic [EP_W-1:0]   LastEp   = EP_W'(N_EPOCHS - 1);
    localparam logic [SLOT_W-1:0] LabelSlot = SLOT_W'(DIM);

    loader_state_e state_q, state_d;

    logic [SMP_W-1:0]   smp_q, smp_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [7:0]         csum_q, csum_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [EP_W-1:0]    epoch_q, epoch_d;
    logic [DIM*8-1:0]   out_x_q, out_x_d;
    logic [7:0]         out_y_q, out_y_d;
    logic               out_last_q, out_last_d;

    logic               in_fire, out_fire, pay_done, is_header;
    logic               rf_we;
    logic [7:0]         rf_wdata;
    logic [DIM*8-1:0]   rf_x;
    logic [7:0]         rf_y;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign pay_done  = (smp_q == SMP_W'(N_SAMPLES));
    assign is_header = (in_data == HEADER);
    assign rf_wdata  = (slot_q == LabelSlot) ? {7'b0, in_data[0]} : in_data;

    sample_regfile #(
        .N_SAMPLES (N_SAMPLES),
        .DIM       (DIM),
        .SMP_W     (SMP_W),
        .SLOT_W    (SLOT_W),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .clk_i       (clk),
        .we_i        (rf_we),
        .wr_sample_i (smp_q),
        .wr_slot_i   (slot_q),
        .wr_data_i   (rf_wdata),
        .rd_idx_i    (idx_d),
        .rd_x_o      (rf_x),
        .rd_y_o      (rf_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (in_fire && is_header) state_d = StLoad;
            StLoad: begin
                if (in_fire && pay_done) begin
                    state_d = (in_data == csum_q) ? StStream : StIdle;
                end
            end
            StStream: begin
                if (out_fire && idx_q == LastIdx && epoch_q == LastEp) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != StStream);
        busy      = (state_q == StLoad) || (state_q == StStream);
        out_valid = (state_q == StStream);
    end

    always_comb begin
        smp_d   = smp_q;
        slot_d  = slot_q;
        csum_d  = csum_q;
        err_d   = err_q;
        idx_d   = idx_q;
        epoch_d = epoch_q;
        rf_we   = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (in_fire && is_header) begin
                    smp_d   = '0;
                    slot_d  = '0;
                    csum_d  = '0;
                    err_d   = 1'b0;
                    epoch_d = '0;
                end
            end
            StLoad: begin
                if (in_fire && !pay_done) begin
                    rf_we  = 1'b1;
                    csum_d = csum_q ^ in_data;
                    if (slot_q == LabelSlot) begin
                        slot_d = '0;
                        smp_d  = smp_q + SMP_W'(1);
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end else if (in_fire) begin
                    if (in_data == csum_q) begin
                        idx_d   = '0;
                        epoch_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StStream: begin
                if (out_fire) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        epoch_d = epoch_q + EP_W'(1);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
        // Output registers track the sample that will be presented next cycle, so a stall
        // simply reloads the same entry.
        out_x_d    = (state_d == StStream) ? rf_x : '0;
        out_y_d    = (state_d == StStream) ? rf_y : '0;
        out_last_d = (state_d == StStream) && (idx_d == LastIdx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q      <= '0;
            slot_q     <= '0;
            csum_q     <= '0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            epoch_q    <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
            out_last_q <= 1'b0;
        end else begin
            smp_q      <= smp_d;
            slot_q     <= slot_d;
            csum_q     <= csum_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            epoch_q    <= epoch_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_x    = out_x_q;
    assign out_y    = out_y_q;
    assign out_idx  = idx_q;
    assign out_last = out_last_q;
    assign epoch    = epoch_q;
    assign err      = err_q;

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Scoreboard bench for perceptron_sample_loader: frames are modelled into an expected
// sample queue, and a monitor pops and compares every accepted output sample.
module tb_perceptron_sample_loader;

    localparam int NS = 3;
    localparam int DM = 2;
    localparam int NE = 2;
    localparam int NP = NS * (DM + 1);
    localparam logic [7:0] HDR = 8'hA5;

    typedef struct {
        logic [DM*8-1:0] x;
        logic [7:0]      y;
        logic [1:0]      idx;
        logic            last;
        logic [1:0]      ep;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      in_data = 8'h00;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DM*8-1:0] out_x;
    logic [7:0]      out_y;
    logic [1:0]      out_idx;
    logic            out_last;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [1:0]      epoch;
    logic            busy;
    logic            err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_hs  = 0;
    int   rdy_mode = 0;
    int   rdy_pc = 0;
    exp_t exp_q[$];
    logic [7:0] pay [NP];

    perceptron_sample_loader #(
        .N_SAMPLES (NS),
        .DIM       (DM),
        .N_EPOCHS  (NE),
        .HEADER    (HDR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .epoch     (epoch),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Reference model: a good frame yields NE passes over the stored samples in order.
    task automatic model_frame(input logic [7:0] cks, output bit good);
        logic [7:0] x = 8'h00;
        exp_t e;
        foreach (pay[i]) x ^= pay[i];
        good = (x == cks);
        if (good) begin
            for (int p = 0; p < NE; p++) begin
                for (int s = 0; s < NS; s++) begin
                    for (int k = 0; k < DM; k++) e.x[k*8 +: 8] = pay[s*(DM+1) + k];
                    e.y    = {7'b0, pay[s*(DM+1) + DM][0]};
                    e.idx  = 2'(s);
                    e.last = (s == NS - 1);
                    e.ep   = 2'(p);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    function automatic logic [7:0] pay_xor();
        logic [7:0] x = 8'h00;
        foreach (pay[i]) x ^= pay[i];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && g < 200) begin
            tick();
            g++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte: in_ready stuck at 0, got 0 expected 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cks);
        send_byte(HDR);
        foreach (pay[i]) send_byte(pay[i]);
        send_byte(cks);
    endtask

    task automatic drain(input string nm);
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 3000) begin
            tick();
            g++;
        end
        check(nm, 32'(g < 3000), 32'd1);
    endtask

    // out_ready driver: always high, 1,0,0,1 pattern, or random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1: begin
                    out_ready = (rdy_pc % 4 == 0) || (rdy_pc % 4 == 3);
                    rdy_pc++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: stability under stall and in-order scoreboard compare on each handshake.
    initial begin
        logic            held = 1'b0;
        logic [DM*8-1:0] hx;
        logic [7:0]      hy;
        logic [1:0]      hidx;
        logic            hlast;
        exp_t            e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_x", 32'(out_x), 32'(hx));
                    check("stall_y", 32'(out_y), 32'(hy));
                    check("stall_idx", 32'(out_idx), 32'(hidx));
                    check("stall_last", 32'(out_last), 32'(hlast));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_sample: got idx %0d expected none", out_idx);
                    end else begin
                        e = exp_q.pop_front();
                        check("x", 32'(out_x), 32'(e.x));
                        check("y", 32'(out_y), 32'(e.y));
                        check("idx", 32'(out_idx), 32'(e.idx));
                        check("last", 32'(out_last), 32'(e.last));
                        check("epoch", 32'(epoch), 32'(e.ep));
                        n_hs++;
                    end
                end
                held  = out_valid && !out_ready;
                hx    = out_x;
                hy    = out_y;
                hidx  = out_idx;
                hlast = out_last;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        bit         good;
        int         base;
        int         g;
        logic [7:0] cks;

        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_x", 32'(out_x), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_epoch", 32'(epoch), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();

        // Reference frame, out_ready held high.
        pay = '{8'h02, 8'h03, 8'h00, 8'h04, 8'h05, 8'h01, 8'h01, 8'h02, 8'h01};
        model_frame(8'h03, good);
        check("s1_model_good", 32'(good), 32'd1);
        send_frame(8'h03);
        check("s1_first_valid", 32'(out_valid), 32'd1);
        check("s1_first_idx", 32'(out_idx), 32'd0);
        check("s1_first_x", 32'(out_x), 32'h0302);
        check("s1_in_ready", 32'(in_ready), 32'd0);
        check("s1_busy", 32'(busy), 32'd1);
        drain("s1_drain");
        check("s1_epoch_done", 32'(epoch), 32'd2);
        check("s1_valid_done", 32'(out_valid), 32'd0);
        check("s1_in_ready_done", 32'(in_ready), 32'd1);
        check("s1_err", 32'(err), 32'd0);

        // Bad checksum.
        model_frame(8'h04, good);
        send_frame(8'h04);
        check("s2_err", 32'(err), 32'd1);
        check("s2_busy", 32'(busy), 32'd0);
        check("s2_valid", 32'(out_valid), 32'd0);
        repeat (5) tick();
        check("s2_valid_later", 32'(out_valid), 32'd0);

        // Garbage before header, stalling consumer.
        rdy_mode = 1;
        send_byte(8'h11);
        send_byte(8'h22);
        check("s3_garbage_busy", 32'(busy), 32'd0);
        check("s3_err_sticky", 32'(err), 32'd1);
        model_frame(8'h03, good);
        send_frame(8'h03);
        check("s3_err_cleared", 32'(err), 32'd0);
        drain("s3_drain");
        check("s3_epoch_done", 32'(epoch), 32'd2);

        // HEADER value as payload.
        pay[0] = HDR;
        cks = pay_xor();
        model_frame(cks, good);
        send_frame(cks);
        check("s4_err", 32'(err), 32'd0);
        drain("s4_drain");
        check("s4_epoch_done", 32'(epoch), 32'd2);

        // Reset mid-stream, then reload.
        pay[0] = 8'h02;
        model_frame(8'h03, good);
        base = n_hs;
        send_frame(8'h03);
        g = 0;
        while (n_hs < base + 4 && g < 200) begin
            tick();
            g++;
        end
        check("s5_reach4", 32'(n_hs - base), 32'd4);
        rst = 1'b1;
        tick();
        check("s5_valid", 32'(out_valid), 32'd0);
        check("s5_epoch", 32'(epoch), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_in_ready", 32'(in_ready), 32'd1);
        check("s5_idx", 32'(out_idx), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        model_frame(8'h03, good);
        send_frame(8'h03);
        check("s5_restart_idx", 32'(out_idx), 32'd0);
        check("s5_restart_valid", 32'(out_valid), 32'd1);
        drain("s5_drain");
        check("s5_epoch_done", 32'(epoch), 32'd2);

        // Randomised frames with random back-pressure and occasional corruption.
        rdy_mode = 2;
        for (int f = 0; f < 8; f++) begin
            foreach (pay[i]) pay[i] = 8'($urandom);
            cks = pay_xor();
            if ($urandom_range(0, 3) == 0) cks ^= 8'(8'h01 << $urandom_range(0, 7));
            model_frame(cks, good);
            send_frame(cks);
            if (good) begin
                check("rnd_err", 32'(err), 32'd0);
                drain("rnd_drain");
                check("rnd_epoch", 32'(epoch), 32'd2);
            end else begin
                check("rnd_bad_err", 32'(err), 32'd1);
                check("rnd_bad_busy", 32'(busy), 32'd0);
            end
        end
        repeat (4) tick();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/perceptron_sample_loader.md
# perceptron_sample_loader

Upstream feeder for the perceptron trainer. Receives a byte-serial training frame with a header, sample bytes, labels and an XOR checksum, and stores the samples in a local register file. After a good checksum it replays the stored samples to the trainer over a valid/ready stream for a fixed number of epochs. It replaces hard-coded training data with data loaded at run time.

## Interface
Parameters:
- N_SAMPLES, 3, number of training samples per frame
- DIM, 2, features per sample
- N_EPOCHS, 4, full passes over the sample set per loaded frame (≥1)
- HEADER, 8'hA5, frame start byte

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- in_data  in  8  frame byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- out_x  out  DIM*8  sample features; feature k at [8k+7:8k]
- out_y  out  8  label, 8'd0 or 8'd1
- out_idx  out  max(1,$clog2(N_SAMPLES))  sample index
- out_last  out  1  high with the final sample of each epoch
- out_valid  out  1  sample presented
- out_ready  in  1  trainer accepts sample
- epoch  out  $clog2(N_EPOCHS+1)  epochs completed since last load
- busy  out  1  state is LOAD or STREAM
- err  out  1  sticky checksum error; cleared by rst or the next accepted HEADER

## Operation
- Frame layout: HEADER, then for each sample s=0..N_SAMPLES-1: x[s][0..DIM-1], y[s]; then one checksum byte equal to the XOR of all payload bytes (header excluded).
- A byte transfers when in_valid && in_ready at posedge.
- States:
  - IDLE: in_ready=1. Bytes other than HEADER are dropped. HEADER → LOAD; clear byte counter, running XOR and err.
  - LOAD: in_ready=1. Each byte is written to the register file at (sample, slot) and XORed into the running checksum. The label slot stores {7'b0, in_data[0]}. After N_SAMPLES*(DIM+1) payload bytes, the next byte is the checksum.
    - Match → STREAM with idx=0, epoch=0.
    - Mismatch → err=1, IDLE.
  - STREAM: in_ready=0.
    - Present sample idx; out_x/out_y/out_idx/out_last stay stable while out_valid && !out_ready.
    - On handshake, idx increments.
    - At idx=N_SAMPLES-1, idx wraps to 0 and epoch increments.
    - When epoch reaches N_EPOCHS → DONE.
  - DONE: out_valid=0, in_ready=1, epoch holds N_EPOCHS. HEADER → LOAD, which clears epoch. Other bytes are dropped.
- A HEADER value arriving inside LOAD is treated as payload data, not as a restart.
- Reset values: state IDLE; in_ready=1; out_valid=0; out_x=0, out_y=0, out_idx=0, out_last=0; epoch=0; busy=0; err=0.
  - Register file contents are not cleared.
  - Register file contents are unreachable until a fresh frame passes its checksum.
- rst mid-LOAD or mid-STREAM aborts immediately. No partial sample is emitted afterwards.

## Timing
- in_ready and busy are decoded combinationally from the state register.
- Checksum byte accepted at edge t:
  - On a match, out_valid=1 from t+1 with sample 0.
  - On a mismatch, err=1 and the state is IDLE from t+1.
- Outputs are registered. With out_ready held high, one sample transfers per cycle and there are no bubbles, including across epoch boundaries.
- The last handshake of the final epoch at edge t gives out_valid=0 and state DONE at t+1.
- Minimum frame-to-first-sample latency: N_SAMPLES*(DIM+1)+2 accepted bytes, plus 1 cycle.

## Structure
- Shared package perceptron_pkg holds:
  - HEADER_BYTE constant
  - loader state enum (IDLE, LOAD, STREAM, DONE)
  - sample-word width constant (8), also used by the trainer
- One sub-module, sample_regfile:
  - N_SAMPLES × (DIM+1) bytes
  - synchronous write port (sample, slot, data)
  - combinational read of one full sample by index
- The FSM, counters and checksum stay in the top.

## Test plan
- Good frame, default params, N_EPOCHS=2: A5, 02 03 00, 04 05 01, 01 02 01, 03 → 6 transfers with out_x=0302,0504,0201 repeating, out_y=0,1,1, out_last on idx 2, epoch 0→1→2, then DONE.
- Same frame with checksum 04 → no out_valid, err=1, state IDLE; a following good frame clears err and streams.
- Garbage 11 22 before A5 → bytes dropped; stream identical to scenario 1.
- out_ready toggling 1,0,0,1 during STREAM → outputs stable while stalled; every sample appears exactly once per epoch, in order.
- rst pulsed after 4 streamed samples → next cycle out_valid=0, epoch=0, state IDLE; a reload of the same frame restarts at idx 0.
- HEADER value as payload (x[0][0]=A5, checksum adjusted) → stored as data; frame accepted.
